// File: rtl/fp32_mul_feeder_pkg.sv
// Shared FP32 field constants, class-flag indices and the result classifier
// used by the multiplier feeder and its operand FIFO.
package fp32_mul_feeder_pkg;

  localparam int unsigned FP_W     = 32;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned FRAC_MSB = 22;
  localparam logic [7:0]  EXP_ALL1 = 8'hFF;

  localparam int unsigned FLG_W    = 4;
  localparam int unsigned FLG_NAN  = 3;
  localparam int unsigned FLG_INF  = 2;
  localparam int unsigned FLG_ZERO = 1;
  localparam int unsigned FLG_DEN  = 0;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fp_pair_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } out_state_t;

  // IEEE-754 class of a single-precision value; normal numbers give all zeros
  function automatic logic [FLG_W-1:0] classify(input logic [FP_W-1:0] x);
    logic [EXP_MSB-EXP_LSB:0] e;
    logic [FRAC_MSB:0]        f;
    logic [FLG_W-1:0]         fl;
    e            = x[EXP_MSB:EXP_LSB];
    f            = x[FRAC_MSB:0];
    fl           = '0;
    fl[FLG_NAN]  = (e == EXP_ALL1) && (f != '0);
    fl[FLG_INF]  = (e == EXP_ALL1) && (f == '0);
    fl[FLG_ZERO] = (e == '0) && (f == '0);
    fl[FLG_DEN]  = (e == '0) && (f != '0);
    return fl;
  endfunction

endpackage

// File: rtl/fp32_pair_fifo.sv
// Operand-pair FIFO: DEPTH entries of {a, b, tag}, power-of-two wrapping
// pointers with a separate occupancy count; head reads as zero when empty.
module fp32_pair_fifo
  import fp32_mul_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  fp_pair_t                 wr_pair,
  input  logic [TAG_W-1:0]         wr_tag,
  output fp_pair_t                 rd_pair,
  output logic [TAG_W-1:0]         rd_tag,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fp_pair_t           pair_mem [DEPTH];
  logic [TAG_W-1:0]   tag_mem  [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rd_pair = empty ? '0 : pair_mem[rd_ptr];
  assign rd_tag  = empty ? '0 : tag_mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (do_push) begin
      pair_mem[wr_ptr] <= wr_pair;
      tag_mem[wr_ptr]  <= wr_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp32_mul_feeder.sv
// Streaming front end for a combinational FP32 multiplier: buffers operand
// pairs, drives the head pair out and registers each product with tag and class.
module fp32_mul_feeder
  import fp32_mul_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              mul_a,
  output logic [31:0]              mul_b,
  input  logic [31:0]              mul_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               out_flags,
  output logic [3:0]               sticky_flags,
  input  logic                     clr_flags,
  output logic [$clog2(DEPTH):0]   count
);

  out_state_t         state_q;
  out_state_t         state_d;
  logic               load;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  fp_pair_t           head_pair;
  logic [TAG_W-1:0]   head_tag;
  logic [FLG_W-1:0]   res_flags;
  logic [FLG_W-1:0]   sticky_d;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && !fifo_full;
  assign mul_a     = head_pair.a;
  assign mul_b     = head_pair.b;
  assign res_flags = classify(mul_result);

  fp32_pair_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (load),
    .wr_pair ('{a: in_a, b: in_b}),
    .wr_tag  (in_tag),
    .rd_pair (head_pair),
    .rd_tag  (head_tag),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // Output-register FSM: load whenever a pair waits and the slot is free or draining
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    sticky_d = clr_flags ? '0 : sticky_flags;
    case (state_q)
      S_EMPTY: begin
        load = !fifo_empty;
        if (load) state_d = S_FULL;
      end
      S_FULL: begin
        load = !fifo_empty && out_ready;
        if (load)           state_d = S_FULL;
        else if (out_ready) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
    if (load) sticky_d = sticky_d | res_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_tag      <= '0;
      out_flags    <= '0;
      sticky_flags <= '0;
    end else begin
      state_q      <= state_d;
      out_valid    <= (state_d == S_FULL);
      sticky_flags <= sticky_d;
      if (load) begin
        out_result <= mul_result;
        out_tag    <= head_tag;
        out_flags  <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp32_mul_feeder.sv
// Bench for fp32_mul_feeder: a behavioural FP32 multiplier closes the loop;
// a queue scoreboard checks order, values and occupancy every cycle.
module tb_fp32_mul_feeder;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a, in_b;
  logic [TAG_W-1:0]  in_tag;
  logic [31:0]       mul_a, mul_b, mul_result;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [TAG_W-1:0]  out_tag;
  logic [3:0]        out_flags;
  logic [3:0]        sticky_flags;
  logic              clr_flags;
  logic [2:0]        count;

  int n_checks = 0;
  int n_errors = 0;
  int n_popped = 0;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic [3:0]       flags;
    logic [3:0]       sticky;
  } vec_t;
  vec_t vt[5];

  fp32_mul_feeder #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_tag       (in_tag),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_result   (mul_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .clr_flags    (clr_flags),
    .count        (count)
  );

  always #5 clk = ~clk;

  function automatic bit is_nan(input logic [31:0] x);
    return x[30:0] > 31'h7F800000;
  endfunction
  function automatic bit is_inf(input logic [31:0] x);
    return x[30:0] == 31'h7F800000;
  endfunction

  // Class by magnitude ranges: {nan, inf, zero, denorm}
  function automatic logic [3:0] ref_class(input logic [31:0] x);
    if (is_nan(x))                 return 4'b1000;
    if (is_inf(x))                 return 4'b0100;
    if (x[30:0] == 31'h0)          return 4'b0010;
    if (x[30:0] < 31'h00800000)    return 4'b0001;
    return 4'b0000;
  endfunction

  // Truncating FP32 multiply; denormal operands flush to zero except for x*1.0
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] fr;
    int          e;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return 32'h7FC00000;
    if (is_inf(a) || is_inf(b))
      return (a[30:0] == 31'h0 || b[30:0] == 31'h0) ? 32'h7FC00000 : {s, 31'h7F800000};
    if (b[30:0] == 31'h3F800000) return {s, a[30:0]};
    if (a[30:0] == 31'h3F800000) return {s, b[30:0]};
    if (a[30:23] == 8'h0 || b[30:23] == 8'h0) return {s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      fr = p[46:24];
      e  = e + 1;
    end else begin
      fr = p[45:23];
    end
    if (e >= 255) return {s, 31'h7F800000};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], fr};
  endfunction

  always_comb mul_result = fmul(mul_a, mul_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: scoreboard handshakes, advance, then check occupancy
  task automatic tick();
    bit   pushed;
    bit   popped;
    exp_t e;
    pushed = in_valid && in_ready;
    popped = out_valid && out_ready;
    if (popped) begin
      n_popped++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_result", out_result, e.res);
        chk("sb_tag", 32'(out_tag), 32'(e.tag));
        chk("sb_flags", 32'(out_flags), 32'(ref_class(e.res)));
      end
    end
    if (pushed) sb.push_back('{res: fmul(in_a, in_b), tag: in_tag});
    @(posedge clk);
    #1;
    chk("occupancy", 32'(int'(count) + int'(out_valid)), 32'(sb.size()));
    if (int'(count) > DEPTH) chk("count_bound", 32'(count), 32'(DEPTH));
  endtask

  initial begin
    logic [31:0]      held_res;
    logic [TAG_W-1:0] held_tag;
    int               pushes;
    int               cyc;

    vt[0] = '{32'h40000000, 32'h40400000, 4'd3, 32'h40C00000, 4'b0000, 4'b0000};
    vt[1] = '{32'h00000000, 32'h7F800000, 4'd4, 32'h7FC00000, 4'b1000, 4'b1000};
    vt[2] = '{32'hFF800000, 32'hC0400000, 4'd5, 32'h7F800000, 4'b0100, 4'b1100};
    vt[3] = '{32'h00000000, 32'h40A00000, 4'd6, 32'h00000000, 4'b0010, 4'b1110};
    vt[4] = '{32'h00000001, 32'h3F800000, 4'd7, 32'h00000001, 4'b0001, 4'b1111};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0; clr_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_mul_a", mul_a, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, back-to-back, one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        in_valid = 1'b1; in_a = vt[i].a; in_b = vt[i].b; in_tag = vt[i].tag;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i == 0) chk("latency_not_yet", 32'(out_valid), 32'd0);
      if (i > 0) begin
        chk("vec_valid", 32'(out_valid), 32'd1);
        chk("vec_result", out_result, vt[i-1].res);
        chk("vec_tag", 32'(out_tag), 32'(vt[i-1].tag));
        chk("vec_flags", 32'(out_flags), 32'(vt[i-1].flags));
        chk("vec_sticky", 32'(sticky_flags), 32'(vt[i-1].sticky));
      end
    end
    tick();
    chk("vec_drained", 32'(out_valid), 32'd0);

    // Backpressure: buffer one held result plus DEPTH entries
    out_ready = 1'b0;
    pushes = 0;
    n_popped = 0;
    for (cyc = 0; cyc < 20 && pushes < 5; cyc++) begin
      in_valid = 1'b1; in_a = 32'h3F800000 + 32'(pushes << 20);
      in_b = 32'h40000000; in_tag = TAG_W'(pushes);
      if (in_ready) pushes++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_pushes", 32'(pushes), 32'd5);
    chk("bp_count_full", 32'(count), 32'(DEPTH));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    held_res = out_result;
    held_tag = out_tag;
    in_valid = 1'b1; in_tag = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_result", out_result, held_res);
      chk("bp_hold_tag", 32'(out_tag), 32'(held_tag));
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (cyc = 0; cyc < 20 && sb.size() > 0; cyc++) tick();
    chk("bp_drain", 32'(sb.size()), 32'd0);
    chk("bp_popped", 32'(n_popped), 32'd5);

    // Wrap-around with random valid/ready
    pushes = 0;
    for (cyc = 0; cyc < 400 && (pushes < 3*DEPTH || sb.size() > 0); cyc++) begin
      in_valid  = (pushes < 3*DEPTH) && ($urandom_range(0, 3) != 0);
      in_a      = $urandom;
      in_b      = $urandom;
      in_tag    = TAG_W'(pushes);
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) pushes++;
      tick();
    end
    in_valid = 1'b0;
    chk("wrap_done", 32'(sb.size()), 32'd0);
    chk("wrap_pushes", 32'(pushes), 32'(3*DEPTH));
    out_ready = 1'b1;
    tick();

    // Clear collides with a NaN load; then clear alone
    in_valid = 1'b1; in_a = 32'h00000000; in_b = 32'h7F800000; in_tag = 4'd5;
    tick();
    in_valid = 1'b0;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clr_with_load", 32'(sticky_flags), 32'h8);
    tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clr_no_load", 32'(sticky_flags), 32'h0);

    // Reset mid-stream with a held result and three queued pairs
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40000000; in_tag = TAG_W'(k + 1);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40400000; in_tag = 4'd9;
    tick();
    in_valid = 1'b0;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_tag", 32'(out_tag), 32'd9);
    chk("post_rst_result", out_result, 32'h40C00000);
    tick();
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
